// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder.
// State encoding is also used by application FSMs for debug display.
package button_event_decoder_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_GAP       = 3'd3,
    ST_PRESS2    = 3'd4
  } state_t;

endpackage

// File: rtl/button_event_decoder_tick_gen.sv
// Free-running 2^N prescaler; tick is high while the count is zero,
// so the first tick lands on the first cycle after reset.
module tick_gen #(
  parameter int N = 19
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= '0;
    else       r_q <= r_q + N'(1);
  end

  assign tick = (r_q == '0);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press, short, long and
// double press pulses, plus a held level and a wrapping press count.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int N          = 19,
  parameter int LONG_TICKS = 96,
  parameter int DBL_TICKS  = 24,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       db,
  output logic       press_tick,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       held,
  output logic [7:0] press_cnt
);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_TICKS - 1);

  logic          w_tick;
  logic          w_rise;
  logic          w_short;
  logic          w_long;
  logic          w_double;
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_tcnt;
  logic          r_db_prev;
  logic          r_press_tick;
  logic          r_short;
  logic          r_long;
  logic          r_double;
  logic          r_held;
  logic [7:0]    r_cnt;

  tick_gen #(.N(N)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_rise = db & ~r_db_prev;

  // Level checks take priority over timer expiry in every state
  always_comb begin
    w_next   = r_state;
    w_short  = 1'b0;
    w_long   = 1'b0;
    w_double = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (db) w_next = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (!db) begin
          w_next = ST_GAP;
        end else if (w_tick && r_tcnt == LONG_LAST) begin
          w_next = ST_LONG_HELD;
          w_long = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (!db) w_next = ST_IDLE;
      end
      ST_GAP: begin
        if (db) begin
          w_next   = ST_PRESS2;
          w_double = 1'b1;
        end else if (w_tick && r_tcnt == DBL_LAST) begin
          w_next  = ST_IDLE;
          w_short = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (!db) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_tcnt       <= '0;
      r_db_prev    <= 1'b0;
      r_press_tick <= 1'b0;
      r_short      <= 1'b0;
      r_long       <= 1'b0;
      r_double     <= 1'b0;
      r_held       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_next;
      r_tcnt       <= (w_next != r_state) ? '0 : r_tcnt + CW'(w_tick);
      r_db_prev    <= db;
      r_press_tick <= w_rise;
      r_short      <= w_short;
      r_long       <= w_long;
      r_double     <= w_double;
      r_held       <= db;
      r_cnt        <= r_cnt + 8'(w_rise);
    end
  end

  assign press_tick   = r_press_tick;
  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_press = r_double;
  assign held         = r_held;
  assign press_cnt    = r_cnt;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios and random
// level runs checked cycle by cycle against a timestamp-based model.
module tb_button_event_decoder;

  localparam int N  = 3;
  localparam int LT = 4;
  localparam int DT = 3;
  localparam int CW = 8;
  localparam int P  = 1 << N;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       db = 1'b0;
  logic       press_tick;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       held;
  logic [7:0] press_cnt;

  button_event_decoder #(
    .N(N), .LONG_TICKS(LT), .DBL_TICKS(DT), .CW(CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .db           (db),
    .press_tick   (press_tick),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .held         (held),
    .press_cnt    (press_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int k = 0;
  int e_now = 0;

  // Model: phase of the gesture plus the edge index where it began;
  // timer expiry is the n-th multiple of P strictly after that edge.
  int m_phase;
  int m_entry;
  int m_cnt;
  bit m_prev;
  bit x_pt, x_s, x_l, x_d, x_h;

  logic [12:0] w_obs;
  assign w_obs = {press_tick, short_press, long_press,
                  double_press, held, press_cnt};

  function automatic logic [12:0] x_vec();
    return {x_pt, x_s, x_l, x_d, x_h, 8'(m_cnt)};
  endfunction

  task automatic m_clear();
    m_phase = 0; m_entry = 0; m_cnt = 0; m_prev = 0;
    x_pt = 0; x_s = 0; x_l = 0; x_d = 0; x_h = 0;
  endtask

  task automatic m_step(input bit d, input int e);
    int nt;
    int np;
    bit tk;
    tk = (e % P == 0);
    nt = e / P - m_entry / P;
    x_pt = d && !m_prev;
    if (x_pt) m_cnt = (m_cnt + 1) % 256;
    x_h = d;
    m_prev = d;
    x_s = 0; x_l = 0; x_d = 0;
    np = m_phase;
    case (m_phase)
      0: if (d) np = 1;
      1: if (!d) np = 3;
         else if (tk && nt == LT) begin np = 2; x_l = 1; end
      2: if (!d) np = 0;
      3: if (d) begin np = 4; x_d = 1; end
         else if (tk && nt == DT) begin np = 0; x_s = 1; end
      default: if (!d) np = 0;
    endcase
    if (np != m_phase) begin
      m_phase = np;
      m_entry = e;
    end
  endtask

  task automatic cyc(input bit d);
    db = d;
    @(posedge clk);
    e_now = k;
    m_step(d, k);
    k++;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    db = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_clear();
    k = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (w_obs !== 13'd0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", w_obs);
    end
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0);
      total++;
      if (w_obs !== x_vec()) begin
        bad++;
        $display("FAIL reset_idle e=%0d got=%h exp=%h", e_now, w_obs, x_vec());
      end
    end
  endtask

  task automatic test_short();
    int pt = 0, sp = 0, lp = 0;
    int t_pt = -1, t_sp = -1, rise = -1, rel = -1;
    for (int i = 0; i < 52; i++) begin
      cyc(i < 12);
      if (i == 0) rise = e_now;
      if (i == 12) rel = e_now;
      total++;
      if (w_obs !== x_vec()) begin
        bad++;
        $display("FAIL short_model e=%0d got=%h exp=%h", e_now, w_obs, x_vec());
      end
      if (press_tick) begin pt++; t_pt = e_now; end
      if (short_press) begin sp++; t_sp = e_now; end
      if (long_press) lp++;
    end
    total++;
    if (pt != 1 || t_pt != rise) begin
      bad++;
      $display("FAIL short_ptick got=%0d@%0d exp=1@%0d", pt, t_pt, rise);
    end
    total++;
    if (sp != 1 || t_sp - rel < 17 || t_sp - rel > 24) begin
      bad++;
      $display("FAIL short_pulse got=%0d delay=%0d exp=1 in 17..24", sp, t_sp - rel);
    end
    total++;
    if (lp != 0 || press_cnt !== 8'd1) begin
      bad++;
      $display("FAIL short_misc long=%0d cnt=%0d exp=0,1", lp, press_cnt);
    end
  endtask

  task automatic test_long();
    int lp = 0, sp = 0, t_lp = -1, rise = -1;
    for (int i = 0; i < 70; i++) begin
      cyc(i < 40);
      if (i == 0) rise = e_now;
      total++;
      if (w_obs !== x_vec()) begin
        bad++;
        $display("FAIL long_model e=%0d got=%h exp=%h", e_now, w_obs, x_vec());
      end
      if (long_press) begin lp++; t_lp = e_now; end
      if (short_press) sp++;
    end
    total++;
    if (lp != 1 || t_lp - rise < 25 || t_lp - rise > 32) begin
      bad++;
      $display("FAIL long_pulse got=%0d delay=%0d exp=1 in 25..32", lp, t_lp - rise);
    end
    total++;
    if (sp != 0) begin
      bad++;
      $display("FAIL long_no_short got=%0d exp=0", sp);
    end
  endtask

  task automatic test_double();
    int dp = 0, sp = 0, t_dp = -1, t_pt2 = -1, rise2 = -1, c0;
    bit d;
    c0 = m_cnt;
    for (int i = 0; i < 70; i++) begin
      d = (i < 10) || (i >= 20 && i < 30);
      cyc(d);
      if (i == 20) rise2 = e_now;
      total++;
      if (w_obs !== x_vec()) begin
        bad++;
        $display("FAIL double_model e=%0d got=%h exp=%h", e_now, w_obs, x_vec());
      end
      if (double_press) begin dp++; t_dp = e_now; end
      if (press_tick && i >= 20) t_pt2 = e_now;
      if (short_press) sp++;
    end
    total++;
    if (dp != 1 || t_dp != rise2 || t_pt2 != rise2) begin
      bad++;
      $display("FAIL double_pulse got=%0d@%0d ptick@%0d exp=1@%0d", dp, t_dp, t_pt2, rise2);
    end
    total++;
    if (sp != 0 || press_cnt !== 8'(c0 + 2)) begin
      bad++;
      $display("FAIL double_misc short=%0d cnt=%0d exp=0,%0d", sp, press_cnt, (c0 + 2) % 256);
    end
  endtask

  task automatic test_boundary();
    int r, x, y, lp = 0, sp = 0, t_sp = -1;
    for (int i = 0; i < 5; i++) cyc(1'b1);
    r = k;
    x = (r / P + DT) * P;
    while (k < x) begin
      cyc(1'b0);
      total++;
      if (w_obs !== x_vec()) begin
        bad++;
        $display("FAIL gap_model e=%0d got=%h exp=%h", e_now, w_obs, x_vec());
      end
    end
    cyc(1'b1);
    total++;
    if (double_press !== 1'b1 || short_press !== 1'b0 || w_obs !== x_vec()) begin
      bad++;
      $display("FAIL gap_tie got d=%b s=%b exp d=1 s=0", double_press, short_press);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0);
    y = k;
    x = (y / P + LT) * P;
    while (k < x) begin
      cyc(1'b1);
      if (long_press) lp++;
    end
    cyc(1'b0);
    if (long_press) lp++;
    total++;
    if (lp != 0 || w_obs !== x_vec()) begin
      bad++;
      $display("FAIL long_tie got long=%0d exp=0", lp);
    end
    y = (x / P + DT) * P;
    while (k <= y + 2) begin
      cyc(1'b0);
      if (short_press) begin sp++; t_sp = e_now; end
    end
    total++;
    if (sp != 1 || t_sp != y) begin
      bad++;
      $display("FAIL long_tie_short got=%0d@%0d exp=1@%0d", sp, t_sp, y);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1);
      total++;
      if (w_obs !== x_vec()) begin
        bad++;
        $display("FAIL wrap_model e=%0d got=%h exp=%h", e_now, w_obs, x_vec());
      end
      cyc(1'b0);
    end
    total++;
    if (press_cnt !== 8'd0) begin
      bad++;
      $display("FAIL wrap_cnt got=%0d exp=0", press_cnt);
    end
    for (int i = 0; i < 30; i++) cyc(1'b0);
  endtask

  task automatic test_reset_mid();
    int ev = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1);
    #1 reset = 1'b1;
    db = 1'b0;
    #1;
    total++;
    if (w_obs !== 13'd0) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=0", w_obs);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_clear();
    k = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0);
      total++;
      if (w_obs !== x_vec()) begin
        bad++;
        $display("FAIL post_reset e=%0d got=%h exp=%h", e_now, w_obs, x_vec());
      end
      ev += int'(short_press) + int'(long_press) + int'(double_press) + int'(press_tick);
    end
    total++;
    if (ev != 0) begin
      bad++;
      $display("FAIL post_reset_events got=%0d exp=0", ev);
    end
  endtask

  task automatic test_random();
    int multi = 0, len;
    bit lvl = 0;
    int n = 0;
    while (n < 3000) begin
      lvl = ~lvl;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        cyc(lvl);
        n++;
        total++;
        if (w_obs !== x_vec()) begin
          bad++;
          $display("FAIL random e=%0d got=%h exp=%h", e_now, w_obs, x_vec());
        end
        if (int'(short_press) + int'(long_press) + int'(double_press) > 1) multi++;
      end
    end
    total++;
    if (multi != 0) begin
      bad++;
      $display("FAIL exclusive got=%0d exp=0", multi);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_boundary();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
